display_timings: RTL and testbench
==================================

DISPLAY_TIMINGS -- requirements
Module: display_timings

Interface
REQ-001 Parameter H_RES, default 640, active pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_RES, default 480, active lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter H_POL, default 0, hsync active level.
REQ-010 Parameter V_POL, default 0, vsync active level.
REQ-011 i_clk  in  1  pixel clock; the block's only clock.
REQ-012 i_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-013 i_en  in  1  advance enable; counters hold when low.
REQ-014 o_hs  out  1  horizontal sync, level per H_POL.
REQ-015 o_vs  out  1  vertical sync, level per V_POL.
REQ-016 o_de  out  1  display enable, high on active pixels.
REQ-017 o_ctrl  out  2  {vsync-active, hsync-active} for the blue-channel TMDS control code (active-high, independent of polarity).
REQ-018 o_sx  out  12  current horizontal pixel position.
REQ-019 o_sy  out  12  current line position.
REQ-020 o_frame  out  1  one-cycle pulse at first pixel of each frame.
REQ-021 o_line  out  1  one-cycle pulse at first pixel of each line.

Function
REQ-022 Horizontal counter hx SHALL count 0..H_TOTAL-1 (H_TOTAL=H_RES+H_FP+H_SYNC+H_BP), wrap to 0, and increment vertical counter vy on wrap.
REQ-023 vy SHALL count 0..V_TOTAL-1 and wrap to 0 on the same cycle hx wraps from H_TOTAL-1 at vy=V_TOTAL-1.
REQ-024 Horizontal phase FSM SHALL have states ACTIVE, FRONT, SYNC, BACK; transitions at hx = H_RES, H_RES+H_FP, H_RES+H_FP+H_SYNC, H_TOTAL (->ACTIVE); the vertical FSM mirrors it on line boundaries.
REQ-025 All outputs SHALL be registered, reflecting counter state (hx,vy) with one cycle latency.
REQ-026 o_de = (hx<H_RES)&&(vy<V_RES); o_hs active while horizontal FSM is SYNC; o_vs active for the whole lines in vertical SYNC, changing at hx=0.
REQ-027 o_sx/o_sy SHALL equal hx/vy (not clamped in blanking).
REQ-028 o_line SHALL pulse when hx=0; o_frame when hx=0 and vy=0; both only on cycles with i_en high.
REQ-029 When i_en is low, counters, FSM and all level outputs SHALL hold, and pulses SHALL be 0.
REQ-030 Parameter sums SHALL fit 12 bits; elaboration SHALL fail if H_TOTAL or V_TOTAL exceeds 4095 or any sync width is 0.

Reset
REQ-031 On i_rst_n low, asynchronously: hx=vy=0, FSMs ACTIVE, o_de=0, o_hs=~H_POL, o_vs=~V_POL, o_ctrl=0, o_sx=o_sy=0, o_frame=o_line=0.
REQ-032 First cycle after release with i_en high SHALL present (0,0) on the next edge with o_frame=o_line=1 and o_de=1; reset mid-line SHALL abort the line with no partial sync pulse retained.

Configuration
REQ-033 Macro DISPLAY_TIMINGS_LOOKAHEAD_EN defined: o_hs, o_vs, o_de, o_ctrl SHALL be delayed one additional register stage (o_sx/o_sy/pulses unchanged), so a one-cycle pixel generator plus the TMDS encoder align; undefined: all outputs share the single-cycle latency of REQ-025.
REQ-034 With the macro defined, the extra stage SHALL reset to the REQ-031 values and hold when i_en is low.

Structure
REQ-035 Shared package display_pkg SHALL hold the 12-bit coordinate typedef, the phase enum (ACTIVE/FRONT/SYNC/BACK) and the 640x480 default constants.
REQ-036 One sub-module, timing_axis, SHALL implement a single counter+phase FSM, instantiated twice (horizontal, vertical-stepped-by-line-wrap).

Verification
REQ-037 Reset, release, i_en=1: first o_frame after 1 cycle; next o_frame exactly 420000 cycles later (800x525).
REQ-038 Line 0: o_hs low for cycles with o_sx 656..751 (96 cycles), o_de high for o_sx 0..639, o_line every 800 cycles.
REQ-039 o_vs low exactly for o_sy 490..491, edges coincident with o_sx=0; o_ctrl=2'b10 during those lines outside hsync, 2'b11 during hsync.
REQ-040 i_en toggled 1/0 alternately: frame period doubles to 840000 cycles, no pulse while i_en=0.
REQ-041 i_rst_n asserted at o_sx=700,o_sy=100 asynchronously: outputs reach REQ-031 values before next edge; restart at (0,0).
REQ-042 Build with DISPLAY_TIMINGS_LOOKAHEAD_EN: o_de rises one cycle after o_sx=0 appears; without it, same cycle.

Source files
------------

// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display timing generator:
//   - coord_t  : 12-bit pixel/line coordinate type
//   - phase_e  : blanking phase of one axis (ACTIVE/FRONT/SYNC/BACK)
//   - DEF_*    : 640x480@60 (800x525 total) default timing constants
//   - axis_total() : total length of one axis from its four segments
// ---------------------------------------------------------------------------
package display_pkg;

   localparam int COORD_W   = 12;
   localparam int COORD_MAX = (1 << COORD_W) - 1;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } phase_e;

   localparam int DEF_H_RES  = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_RES  = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;

   function automatic int axis_total(input int res, input int fp,
                                     input int sync_w, input int bp);
      return res + fp + sync_w + bp;
   endfunction

endpackage

// File: rtl/display_timings_if.sv
// ---------------------------------------------------------------------------
// display_timings_if
// Bundles the timing generator's enable input and its video timing outputs.
//   i_en    : advance enable (driven by the consumer)
//   o_hs    : horizontal sync (polarity set by the generator)
//   o_vs    : vertical sync (polarity set by the generator)
//   o_de    : display enable
//   o_ctrl  : {vsync-active, hsync-active}, active-high TMDS control code
//   o_sx    : current pixel position
//   o_sy    : current line position
//   o_frame : one-cycle pulse on the first pixel of a frame
//   o_line  : one-cycle pulse on the first pixel of a line
// Modports: master = timing generator, slave = pixel pipeline / consumer.
// ---------------------------------------------------------------------------
interface display_timings_if;
   import display_pkg::*;

   logic       i_en;
   logic       o_hs;
   logic       o_vs;
   logic       o_de;
   logic [1:0] o_ctrl;
   coord_t     o_sx;
   coord_t     o_sy;
   logic       o_frame;
   logic       o_line;

   modport master (
      input  i_en,
      output o_hs, o_vs, o_de, o_ctrl, o_sx, o_sy, o_frame, o_line
   );

   modport slave (
      output i_en,
      input  o_hs, o_vs, o_de, o_ctrl, o_sx, o_sy, o_frame, o_line
   );

endinterface

// File: rtl/timing_axis.sv
// ---------------------------------------------------------------------------
// timing_axis
// One timing axis: a counter running 0..TOTAL-1 plus a phase FSM that
// tracks which segment (active, front porch, sync, back porch) the counter
// is in. Used once per pixel for the horizontal axis and once per line
// wrap for the vertical axis.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_step     : advance the counter by one this cycle
//   o_count    : current count
//   o_phase    : phase that o_count lies in
// ---------------------------------------------------------------------------
module timing_axis
   import display_pkg::*;
#(
   parameter int RES    = DEF_H_RES,
   parameter int FP     = DEF_H_FP,
   parameter int SYNC_W = DEF_H_SYNC,
   parameter int BP     = DEF_H_BP
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_step,
   output coord_t o_count,
   output phase_e o_phase
);

   localparam int TOTAL = axis_total(RES, FP, SYNC_W, BP);

   localparam coord_t C_FRONT = coord_t'(RES);
   localparam coord_t C_SYNC  = coord_t'(RES + FP);
   localparam coord_t C_BACK  = coord_t'(RES + FP + SYNC_W);
   localparam coord_t C_LAST  = coord_t'(TOTAL - 1);

   // A zero-length front porch goes straight from active into sync.
   localparam phase_e AFTER_ACTIVE = (FP == 0) ? SYNC : FRONT;

   if (TOTAL > COORD_MAX || SYNC_W == 0 || RES == 0) begin : g_bad_params
      $error("timing_axis: total exceeds 4095, or sync/active width is 0");
   end

   coord_t count_q, count_d;
   phase_e phase_q, phase_d;

   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      if (i_step) begin
         if (count_q == C_LAST) begin
            count_d = '0;
         end else begin
            count_d = count_q + coord_t'(1);
         end

         // Phase follows the value the counter is about to take.
         case (phase_q)
            ACTIVE: if (count_d == C_FRONT) phase_d = AFTER_ACTIVE;
            FRONT:  if (count_d == C_SYNC)  phase_d = SYNC;
            SYNC: begin
               // With no back porch the wrap to 0 ends sync directly.
               if (count_d == '0) begin
                  phase_d = ACTIVE;
               end else if (count_d == C_BACK) begin
                  phase_d = BACK;
               end
            end
            BACK:   if (count_d == '0) phase_d = ACTIVE;
            default: phase_d = ACTIVE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         phase_q <= ACTIVE;
      end else begin
         count_q <= count_d;
         phase_q <= phase_d;
      end
   end

   assign o_count = count_q;
   assign o_phase = phase_q;

endmodule

// File: rtl/display_timings.sv
// ---------------------------------------------------------------------------
// display_timings
// Video timing generator (default 640x480, 800x525 total). Produces sync,
// display-enable, TMDS control code, coordinates and frame/line pulses,
// all registered from the counter state with one cycle of latency.
// Ports:
//   i_clk   : pixel clock
//   i_rst_n : asynchronous active-low reset
//   bus     : display_timings_if.master (i_en in, timing outputs out)
// Configuration macro DISPLAY_TIMINGS_LOOKAHEAD_EN: when defined, o_hs,
// o_vs, o_de and o_ctrl pass through one extra register stage so they line
// up with a one-cycle pixel generator feeding a TMDS encoder; o_sx, o_sy
// and the pulses keep the single-cycle latency.
// ---------------------------------------------------------------------------
module display_timings
   import display_pkg::*;
#(
   parameter int H_RES  = DEF_H_RES,
   parameter int H_FP   = DEF_H_FP,
   parameter int H_SYNC = DEF_H_SYNC,
   parameter int H_BP   = DEF_H_BP,
   parameter int V_RES  = DEF_V_RES,
   parameter int V_FP   = DEF_V_FP,
   parameter int V_SYNC = DEF_V_SYNC,
   parameter int V_BP   = DEF_V_BP,
   parameter bit H_POL  = 1'b0,
   parameter bit V_POL  = 1'b0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   display_timings_if.master  bus
);

   localparam int     H_TOTAL = axis_total(H_RES, H_FP, H_SYNC, H_BP);
   localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);

   coord_t hx, vy;
   phase_e h_phase, v_phase;
   logic   h_wrap, v_step;

   assign h_wrap = (hx == H_LAST);
   assign v_step = bus.i_en & h_wrap;

   timing_axis #(
      .RES(H_RES), .FP(H_FP), .SYNC_W(H_SYNC), .BP(H_BP)
   ) u_h_axis (
      .clk(i_clk), .rst_n(i_rst_n), .i_step(bus.i_en),
      .o_count(hx), .o_phase(h_phase)
   );

   // Vertical axis advances once per horizontal wrap, so vy and the
   // vertical phase change exactly as hx returns to 0.
   timing_axis #(
      .RES(V_RES), .FP(V_FP), .SYNC_W(V_SYNC), .BP(V_BP)
   ) u_v_axis (
      .clk(i_clk), .rst_n(i_rst_n), .i_step(v_step),
      .o_count(vy), .o_phase(v_phase)
   );

   logic hs_act, vs_act;
   assign hs_act = (h_phase == SYNC);
   assign vs_act = (v_phase == SYNC);

   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       de_q, de_d;
   logic [1:0] ctrl_q, ctrl_d;
   coord_t     sx_q, sx_d;
   coord_t     sy_q, sy_d;
   logic       frame_q, frame_d;
   logic       line_q, line_d;

   // Output stage: levels hold and pulses drop while i_en is low.
   always_comb begin
      hs_d    = hs_q;
      vs_d    = vs_q;
      de_d    = de_q;
      ctrl_d  = ctrl_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      frame_d = 1'b0;
      line_d  = 1'b0;
      if (bus.i_en) begin
         hs_d    = hs_act ? H_POL : ~H_POL;
         vs_d    = vs_act ? V_POL : ~V_POL;
         de_d    = (h_phase == ACTIVE) && (v_phase == ACTIVE);
         ctrl_d  = {vs_act, hs_act};
         sx_d    = hx;
         sy_d    = vy;
         line_d  = (hx == '0);
         frame_d = (hx == '0) && (vy == '0);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hs_q    <= ~H_POL;
         vs_q    <= ~V_POL;
         de_q    <= 1'b0;
         ctrl_q  <= 2'b00;
         sx_q    <= '0;
         sy_q    <= '0;
         frame_q <= 1'b0;
         line_q  <= 1'b0;
      end else begin
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         de_q    <= de_d;
         ctrl_q  <= ctrl_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         frame_q <= frame_d;
         line_q  <= line_d;
      end
   end

   assign bus.o_sx    = sx_q;
   assign bus.o_sy    = sy_q;
   assign bus.o_frame = frame_q;
   assign bus.o_line  = line_q;

`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
   logic       hs2_q, hs2_d;
   logic       vs2_q, vs2_d;
   logic       de2_q, de2_d;
   logic [1:0] ctrl2_q, ctrl2_d;

   // Extra delay stage for the level outputs; it advances only with i_en
   // so a stalled pipeline stays aligned.
   always_comb begin
      hs2_d   = hs2_q;
      vs2_d   = vs2_q;
      de2_d   = de2_q;
      ctrl2_d = ctrl2_q;
      if (bus.i_en) begin
         hs2_d   = hs_q;
         vs2_d   = vs_q;
         de2_d   = de_q;
         ctrl2_d = ctrl_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         hs2_q   <= ~H_POL;
         vs2_q   <= ~V_POL;
         de2_q   <= 1'b0;
         ctrl2_q <= 2'b00;
      end else begin
         hs2_q   <= hs2_d;
         vs2_q   <= vs2_d;
         de2_q   <= de2_d;
         ctrl2_q <= ctrl2_d;
      end
   end

   assign bus.o_hs   = hs2_q;
   assign bus.o_vs   = vs2_q;
   assign bus.o_de   = de2_q;
   assign bus.o_ctrl = ctrl2_q;
`else
   assign bus.o_hs   = hs_q;
   assign bus.o_vs   = vs_q;
   assign bus.o_de   = de_q;
   assign bus.o_ctrl = ctrl_q;
`endif

endmodule

// File: tb/tb_display_timings.sv
// ---------------------------------------------------------------------------
// tb_display_timings
// Directed bench for display_timings using a shrunken timing so whole
// frames fit in a short run:
//   horizontal 8 active + 2 FP + 3 sync + 2 BP = 15 (hsync at sx 10..12)
//   vertical   4 active + 1 FP + 2 sync + 1 BP =  8 (vsync at sy 5..6)
//   frame = 15 * 8 = 120 cycles; both syncs active-low.
// Position p (0-based count of enabled edges after reset) shows as
// sx = p % 15, sy = (p / 15) % 8.
// ---------------------------------------------------------------------------
module tb_display_timings;
   import display_pkg::*;

   localparam int H_RES  = 8;
   localparam int H_FP   = 2;
   localparam int H_SYNC = 3;
   localparam int H_BP   = 2;
   localparam int V_RES  = 4;
   localparam int V_FP   = 1;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 1;
   localparam int H_TOT  = 15;
   localparam int V_TOT  = 8;
   localparam int FRAME  = 120;

`ifdef DISPLAY_TIMINGS_LOOKAHEAD_EN
   localparam int LAG = 1;
`else
   localparam int LAG = 0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   num_checks = 0;
   int   num_fail   = 0;

   display_timings_if bus();

   display_timings #(
      .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .H_POL(1'b0), .V_POL(1'b0)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive i_en for one clock edge and return at the following negedge.
   task automatic applyStimulus(input logic en);
      bus.i_en = en;
      @(posedge clk);
      @(negedge clk);
   endtask

   // pos: position shown by sx/sy (-1 = reset); lvl: position the level
   // outputs reflect (-1 = reset values); pulse_edge: last edge had i_en.
   task automatic expectAll(input string tag, input int pos, input int lvl,
                            input logic pulse_edge);
      int   ex_sx, ex_sy, lx, ly;
      logic hs_act, vs_act, ex_de, ex_line, ex_frame;
      ex_sx    = (pos < 0) ? 0 : pos % H_TOT;
      ex_sy    = (pos < 0) ? 0 : (pos / H_TOT) % V_TOT;
      ex_line  = pulse_edge && (pos >= 0) && (ex_sx == 0);
      ex_frame = ex_line && (ex_sy == 0);
      if (lvl < 0) begin
         hs_act = 1'b0;
         vs_act = 1'b0;
         ex_de  = 1'b0;
      end else begin
         lx     = lvl % H_TOT;
         ly     = (lvl / H_TOT) % V_TOT;
         hs_act = (lx >= 10) && (lx <= 12);
         vs_act = (ly >= 5) && (ly <= 6);
         ex_de  = (lx < 8) && (ly < 4);
      end
      checkOutput({tag, ".sx"},    32'(bus.o_sx),    32'(ex_sx));
      checkOutput({tag, ".sy"},    32'(bus.o_sy),    32'(ex_sy));
      checkOutput({tag, ".hs"},    32'(bus.o_hs),    32'(!hs_act));
      checkOutput({tag, ".vs"},    32'(bus.o_vs),    32'(!vs_act));
      checkOutput({tag, ".de"},    32'(bus.o_de),    32'(ex_de));
      checkOutput({tag, ".ctrl"},  32'(bus.o_ctrl),  32'({vs_act, hs_act}));
      checkOutput({tag, ".frame"}, 32'(bus.o_frame), 32'(ex_frame));
      checkOutput({tag, ".line"},  32'(bus.o_line),  32'(ex_line));
   endtask

   initial begin
      int   first_frame, second_frame, m;
      logic en_now;

      rst_n    = 1'b0;
      bus.i_en = 1'b0;
      repeat (2) @(negedge clk);
      expectAll("reset", -1, -1, 1'b0);

      // Free-running frame: first frame pulse one edge after release,
      // the next one exactly 120 edges later.
      rst_n = 1'b1;
      first_frame  = -1;
      second_frame = -1;
      for (int k = 0; k <= FRAME; k++) begin
         applyStimulus(1'b1);
         if (bus.o_frame) begin
            if (first_frame < 0) first_frame = k;
            else if (second_frame < 0) second_frame = k;
         end
         expectAll("scan", k, k - LAG, 1'b1);
      end
      checkOutput("first_frame_edge", 32'(first_frame), 32'd0);
      checkOutput("frame_period", 32'(second_frame - first_frame), 32'(FRAME));

      // Abort mid-line inside hsync (position 26 = sx 11, sy 1).
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k <= 26; k++) begin
         applyStimulus(1'b1);
      end
      expectAll("pre_abort", 26, 26 - LAG, 1'b1);
      checkOutput("pre_abort_hs_low", 32'(bus.o_hs), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      expectAll("abort", -1, -1, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1);
      expectAll("restart", 0, -LAG, 1'b1);

      // Alternating enable: everything moves on enabled edges only, so
      // the frame period doubles to 240 edges.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m = 0;
      first_frame  = -1;
      second_frame = -1;
      for (int j = 0; j <= 2 * FRAME + 1; j++) begin
         en_now = (j % 2 == 0);
         applyStimulus(en_now);
         if (en_now) m++;
         if (bus.o_frame) begin
            if (first_frame < 0) first_frame = j;
            else if (second_frame < 0) second_frame = j;
         end
         expectAll("toggle", m - 1, m - 1 - LAG, en_now);
      end
      checkOutput("toggle_period", 32'(second_frame - first_frame), 32'(2 * FRAME));

      $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fail);
      $finish;
   end

endmodule
